// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv_instr(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_is_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_is_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero-operand cases bypass the iteration phase.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N_Bits = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [N_Bits-1:0] op_a,
    input  logic [N_Bits-1:0] op_b,
    input  logic [4:0]        rd_in,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [4:0]        rd_out,
    output logic [N_Bits-1:0] result
);

    localparam int CW = $clog2(N_Bits);
    localparam logic [N_Bits-1:0] MIN_VAL = {1'b1, {(N_Bits-1){1'b0}}};

    muldiv_state_t state, state_n;
    muldiv_op_t    op_q, op_in;

    logic [CW-1:0]       cnt;
    logic [N_Bits-1:0]   a_mag, b_mag, quo, rem;
    logic [2*N_Bits-1:0] prod;
    logic                neg_res, neg_rem;
    logic [4:0]          rd_q;

    logic                a_neg_in, b_neg_in;
    logic [N_Bits-1:0]   a_mag_in, b_mag_in;
    logic                div_zero, div_ovf, early, special, accept;

    logic [N_Bits:0]     mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*N_Bits-1:0] prod_fix;
    logic [N_Bits-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        op_in    = muldiv_op_t'(funct3);
        a_neg_in = a_is_signed(op_in) & op_a[N_Bits-1];
        b_neg_in = b_is_signed(op_in) & op_b[N_Bits-1];
        a_mag_in = a_neg_in ? -op_a : op_a;
        b_mag_in = b_neg_in ? -op_b : op_b;
        div_zero = is_div(op_in) && (op_b == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (op_a == MIN_VAL) && (op_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early    = is_div(op_in) ? ((op_a == '0) && (op_b != '0))
                                 : ((op_a == '0) || (op_b == '0));
`else
        early    = 1'b0;
`endif
        special  = div_zero | div_ovf | early;
        accept   = (state == IDLE) && start && !flush && !done;
    end

    always_comb begin
        mul_sum   = {1'b0, prod[2*N_Bits-1:N_Bits]} + (prod[0] ? {1'b0, a_mag} : '0);
        div_shift = {rem, quo[N_Bits-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = (div_shift >= {1'b0, b_mag});
    end

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -quo : quo;
        rem_fix  = neg_rem ? -rem : rem;
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[N_Bits-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*N_Bits-1:N_Bits];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = special ? FIN : CALC;
            CALC:    if (flush) state_n = IDLE;
                     else if (cnt == CW'(N_Bits-1)) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Special cases preload quo/rem so the common FIN fix-up yields the defined result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_MUL;
            cnt     <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            quo     <= '0;
            rem     <= '0;
            prod    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            rd_q    <= '0;
            done    <= 1'b0;
            we      <= 1'b0;
            rd_out  <= '0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q    <= op_in;
                    rd_q    <= rd_in;
                    cnt     <= '0;
                    a_mag   <= a_mag_in;
                    b_mag   <= b_mag_in;
                    neg_res <= a_neg_in ^ b_neg_in;
                    neg_rem <= a_neg_in;
                    prod    <= {{N_Bits{1'b0}}, b_mag_in};
                    quo     <= a_mag_in;
                    rem     <= '0;
                    if (div_zero) begin
                        quo     <= '1;
                        rem     <= a_mag_in;
                        neg_res <= 1'b0;
                    end else if (div_ovf) begin
                        quo     <= MIN_VAL;
                        neg_res <= 1'b0;
                    end else if (early) begin
                        prod <= '0;
                        quo  <= '0;
                    end
                end
                CALC: if (!flush) begin
                    cnt <= cnt + 1'b1;
                    if (is_div(op_q)) begin
                        rem <= div_ge ? div_diff[N_Bits-1:0] : div_shift[N_Bits-1:0];
                        quo <= {quo[N_Bits-2:0], div_ge};
                    end else begin
                        prod <= {mul_sum, prod[N_Bits-1:1]};
                    end
                end
                FIN: if (!flush) begin
                    done   <= 1'b1;
                    we     <= (rd_q != '0);
                    rd_out <= rd_q;
                    result <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, protocol checks and random ops
// against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, we;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.N_Bits(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .we(we), .rd_out(rd_out), .result(result)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (f[2] && b == 0) ||
                  ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        special = special || (f[2] ? (a == 0 && b != 0) : (a == 0 || b == 0));
`endif
        return special ? 1 : N + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noise,
                          output logic [31:0] res, output int lat, output logic we_s,
                          output logic [4:0] rd_s, output logic busy_s, output logic idle_after);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        busy_s = busy;
        lat    = 0;
        res    = 'x; we_s = 'x; rd_s = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            busy_s = busy_s & busy;
            if (done) begin
                lat = k; res = result; we_s = we; rd_s = rd_out;
                break;
            end
            if (noise && (k == 5 || k == 20 || k == 32)) begin
                start = 1'b1; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        idle_after = !busy && !done;
    endtask

    task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input bit noise);
        logic [31:0] res;
        int lat;
        logic we_s, busy_s, idle_after;
        logic [4:0] rd_s;
        run_op(f, a, b, rd, noise, res, lat, we_s, rd_s, busy_s, idle_after);
        check({tag, " result"},  res, ref_result(f, a, b));
        check({tag, " latency"}, lat, ref_latency(f, a, b));
        check({tag, " we"},      we_s, rd != 0);
        check({tag, " rd_out"},  rd_s, rd);
        check({tag, " busy"},    busy_s, 1'b1);
        check({tag, " idle"},    idle_after, 1'b1);
    endtask

    initial begin
        logic [31:0] a, b;
        logic saw_done;

        repeat (2) @(negedge clk);
        check("reset busy",   busy, 0);
        check("reset done",   done, 0);
        check("reset we",     we, 0);
        check("reset rd_out", rd_out, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;

        op_check("mul",       3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        op_check("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
        op_check("mulh",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        op_check("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
        op_check("div",       3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, 0);
        op_check("rem",       3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 0);
        op_check("divu",      3'd5, 32'd100, 32'd7, 5'd11, 0);
        op_check("remu",      3'd7, 32'd100, 32'd7, 5'd12, 0);
        op_check("divu0",     3'd5, 32'd5, 32'd0, 5'd13, 0);
        op_check("rem0",      3'd6, 32'd5, 32'd0, 5'd14, 0);
        op_check("remneg0",   3'd6, 32'hFFFF_FFF9, 32'd0, 5'd15, 0);
        op_check("div0",      3'd4, 32'hFFFF_FFF9, 32'd0, 5'd16, 0);
        op_check("divovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);
        op_check("removf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 0);
        op_check("noise",     3'd0, 32'd123456789, 32'd987, 5'd19, 1);
        op_check("rdzero",    3'd5, 32'd1000, 32'd3, 5'd0, 0);
        op_check("mulhneg",   3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd20, 0);

        // Leave a known result in place, then flush mid-iteration
        op_check("preflush",  3'd0, 32'd1234, 32'd5678, 5'd21, 0);
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd99; op_b = 32'd77; rd_in = 5'd22; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1 saw_done = saw_done | done;
        end
        check("flush no done", saw_done, 0);
        check("flush result",  result, 32'd1234 * 32'd5678);
        check("flush rd_out",  rd_out, 5'd21);

        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd23; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        check("flushstart busy", busy, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1 saw_done = saw_done | done;
        end
        check("flushstart no done", saw_done, 0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            op_check("rnd", 3'($urandom), a, b, 5'($urandom_range(0, 31)), 0);
        end

        op_check("prereset", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd5000; op_b = 32'd7; rd_in = 5'd24; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset busy",   busy, 0);
        check("midreset done",   done, 0);
        check("midreset we",     we, 0);
        check("midreset result", result, 0);
        check("midreset rd_out", rd_out, 0);
        @(negedge clk) rst_n = 1'b1;

        op_check("mulzero", 3'd0, 32'd0, 32'd9, 5'd25, 0);
        op_check("divzeroa", 3'd4, 32'd0, 32'd9, 5'd26, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit that sits directly downstream of register_file.
- Consumes RD1/RD2 as operands.
- Produces a registered result, destination index and write-enable that drive WD3/A3/WE3 on write-back.
- Multi-cycle with start/busy/done handshake; the control path stalls the core while busy is high.

Parameters:
- N_Bits, 32, operand/result width (must be even, ≥8)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  N_Bits  rs1 value (from RD1)
- op_b  input  N_Bits  rs2 value (from RD2)
- rd_in  input  5  destination register index
- flush  input  1  abort current operation, no write-back
- busy  output  1  high from cycle after accepted start until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- we  output  1  equals done when rd_out≠0; drives WE3
- rd_out  output  5  latched rd_in; drives A3
- result  output  N_Bits  drives WD3; held until next done

Behaviour:
- Async reset: state IDLE; busy, done, we = 0; rd_out = 0; result = 0; internal accumulators cleared. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIN.
- IDLE: on start, latch funct3, rd_in and operand magnitudes plus sign flags.
  - Signed operands: MULH uses both; MULHSU uses op_a only; DIV/REM use both.
  - Clear iteration counter, then go to CALC.
  - Special cases go directly to FIN: divisor 0, or signed overflow (DIV/REM with op_a=MIN, op_b=−1).
- CALC: one radix-2 step per cycle, exactly N_Bits cycles.
  - Multiply: shift-add into a 2·N_Bits product.
  - Divide: restoring, with remainder width N_Bits+1.
  - Counter hits N_Bits−1 → FIN.
- FIN: apply sign fix-up (negate product if signs differ; quotient if signs differ; remainder takes dividend sign).
  - Select the result: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - done=1 for this cycle; next state IDLE.
- Latency, normal op: done high N_Bits+1 cycles after the start edge (33 for 32-bit). busy is high for the same span.
- Latency, special case: done high 1 cycle after the start edge.
- Divide-by-zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = op_a.
- Signed overflow: quotient = MIN, remainder = 0.
- start while busy or in FIN: ignored, no queuing.
- Back-to-back: start may be accepted in the cycle after done.
- flush in CALC or FIN: next state IDLE, done/we suppressed, result unchanged.
  - flush and start together in IDLE: flush wins, start is dropped.
- Write-back: rd_out=0 keeps we=0 while done still pulses, so x0 is never written.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - MUL* with op_a=0 or op_b=0 skips CALC and reaches FIN with result 0, done 1 cycle after start.
  - DIV*/REM* with op_a=0 and op_b≠0 likewise gives quotient 0 / remainder 0.
- Undefined: these cases take the full N_Bits+1 cycles. Results are identical either way; only latency differs.

Decomposition:
- Shared package muldiv_pkg:
  - typedef enum for funct3 ops (muldiv_op_t)
  - state enum (muldiv_state_t: IDLE, CALC, FIN)
  - localparams for the RV32M opcode/funct7 values used by the decoder
- Single module; no sub-module is warranted. Multiply and divide share the counter and FSM, and the datapath is one always_ff plus a combinational fix-up.

Test Plan:
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, done exactly 33 cycles after start, we=1, rd_out=rd_in=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFEC (−20) / 3 → 0xFFFFFFFA; REM same → 0xFFFFFFFE; DIVU 100/7 → 14; REMU → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All with done 1 cycle after start.
- Protocol:
  - start pulses during busy are ignored, and the result matches the first op.
  - flush at cycle 10 of CALC → no done, busy low next cycle, result unchanged.
  - rd_in=0 → done pulses, we stays 0.
- rst_n asserted mid-CALC → busy/done/we/result/rd_out go 0 immediately. With MULDIV_EARLY_OUT_EN defined, MUL 0 × 9 → result 0, done 1 cycle after start.
